// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch constants (NOP word, default PC width, fetch FSM encoding)
package mips_pkg;
  localparam int PC_W_DEF = 6;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory req/ack port (IMemReq/IMemAddr out of fetch, IMemData/IMemAck back)
interface if_fetch_stage_if import mips_pkg::*; #(parameter int PC_WIDTH = PC_W_DEF) ();
  logic IMemReq;
  logic [PC_WIDTH-1:0] IMemAddr;
  logic [31:0] IMemData;
  logic IMemAck;
  modport master (output IMemReq, IMemAddr, input IMemData, IMemAck);
  modport slave (input IMemReq, IMemAddr, output IMemData, IMemAck);
endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry instruction+PCNext holding buffer; ports clk/rst(low), load, clear(unload), in_*/out_*, full
module fetch_skid_buf import mips_pkg::*; #(parameter int W = PC_W_DEF) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [31:0]  in_instr,
  input  logic [W-1:0] in_pcn,
  output logic [31:0]  out_instr,
  output logic [W-1:0] out_pcn,
  output logic         full
);
  always_ff @(posedge clk)
    if (!rst || clear) begin
      full <= 1'b0;
      out_instr <= NOP_INSTR;
      out_pcn <= '0;
    end else if (load) begin
      full <= 1'b1;
      out_instr <= in_instr;
      out_pcn <= in_pcn;
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC + req/ack fetch FSM + IF/ID register; clk, rst(sync low), hazard/redirect inputs, imem master port, IF/ID outputs, EPC
module if_fetch_stage import mips_pkg::*; #(
  parameter int PC_WIDTH = PC_W_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR = 6'd60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Stall,
  input  logic                Branch,
  input  logic                Iguales,
  input  logic                IF_Flush,
  input  logic                Exception,
  input  logic [PC_WIDTH-1:0] ALUR,
  if_fetch_stage_if.master    imem,
  output logic [31:0]         Instruction,
  output logic [PC_WIDTH-1:0] PCNext,
  output logic                IFID_Valid,
  output logic [PC_WIDTH-1:0] EPC
);
  logic [1:0] st, st_d;
  logic live, req, acc, redir, ld_ifid, ifid_v, buf_ld, buf_clr, buf_full;
  logic [PC_WIDTH-1:0] pc, pc_d, drain_addr, ifid_p, buf_p;
  logic [31:0] ifid_i, buf_i;
  assign req = live & (st != HOLD);
  assign acc = req & imem.IMemAck;
  assign redir = Exception | (Branch & Iguales & ~Stall);
  assign imem.IMemReq = req;
  assign imem.IMemAddr = st == DRAIN ? drain_addr : pc;
  fetch_skid_buf #(.W(PC_WIDTH)) u_buf (
    .clk(clk), .rst(rst), .load(buf_ld), .clear(buf_clr),
    .in_instr(imem.IMemData), .in_pcn(pc + 1'b1),
    .out_instr(buf_i), .out_pcn(buf_p), .full(buf_full)
  );
  always_comb begin
    pc_d = pc;
    st_d = st;
    ld_ifid = 1'b0;
    ifid_i = NOP_INSTR;
    ifid_p = PCNext;
    ifid_v = 1'b0;
    buf_ld = 1'b0;
    buf_clr = 1'b0;
    if (redir) begin
      pc_d = Exception ? EXC_VECTOR : ALUR;
      buf_clr = 1'b1;
      ld_ifid = 1'b1;
      st_d = (req & ~imem.IMemAck) ? DRAIN : FETCH;
    end else if (st == FETCH && acc) begin
      pc_d = pc + 1'b1;
      buf_ld = Stall;
      ld_ifid = ~Stall;
      ifid_i = imem.IMemData;
      ifid_p = pc + 1'b1;
      ifid_v = 1'b1;
      st_d = Stall ? HOLD : FETCH;
    end else if (buf_full && !Stall) begin
      buf_clr = 1'b1;
      ld_ifid = 1'b1;
      ifid_i = buf_i;
      ifid_p = buf_p;
      ifid_v = 1'b1;
      st_d = FETCH;
    end else if (st == DRAIN && acc) begin
      st_d = FETCH;
    end
    if (IF_Flush) begin
      ld_ifid = 1'b1;
      ifid_i = NOP_INSTR;
      ifid_v = 1'b0;
    end
  end
  // live keeps IMemReq low for the first cycle after reset so a late ack to a pre-reset request is ignored
  always_ff @(posedge clk)
    if (!rst) begin
      st <= FETCH;
      live <= 1'b0;
      pc <= RESET_PC;
      drain_addr <= RESET_PC;
      Instruction <= NOP_INSTR;
      PCNext <= '0;
      IFID_Valid <= 1'b0;
      EPC <= '0;
    end else begin
      st <= st_d;
      live <= 1'b1;
      pc <= pc_d;
      if (st == FETCH) drain_addr <= pc;
      if (ld_ifid) begin
        Instruction <= ifid_i;
        PCNext <= ifid_p;
        IFID_Valid <= ifid_v;
      end
      if (Exception) EPC <= PCNext - 1'b1;
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed checks of fetch, wait states, stall skid, branch drain, exception, wrap, reset, flush
module tb_if_fetch_stage;
  logic clk = 0, rst = 0, Stall = 0, Branch = 0, Iguales = 0, IF_Flush = 0, Exception = 0;
  logic zw = 1, ack_f = 0;
  logic [5:0] ALUR = 0;
  logic [31:0] Instruction;
  logic [5:0] PCNext, EPC;
  logic IFID_Valid;
  int total = 0, bad = 0;
  if_fetch_stage_if m();
  assign m.IMemAck = zw ? m.IMemReq : ack_f;
  assign m.IMemData = 32'hA500_0000 | 32'(m.IMemAddr);
  if_fetch_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Branch(Branch), .Iguales(Iguales),
    .IF_Flush(IF_Flush), .Exception(Exception), .ALUR(ALUR), .imem(m),
    .Instruction(Instruction), .PCNext(PCNext), .IFID_Valid(IFID_Valid), .EPC(EPC)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  function automatic logic [31:0] w(int a);
    return 32'hA500_0000 | 32'(a);
  endfunction
  initial begin
    step(2);
    chk("rst_req", 32'(m.IMemReq), 0);
    chk("rst_valid", 32'(IFID_Valid), 0);
    chk("rst_instr", Instruction, 0);
    chk("rst_pcn", 32'(PCNext), 0);
    chk("rst_epc", 32'(EPC), 0);
    rst = 1;
    step;
    chk("start_req", 32'(m.IMemReq), 1);
    chk("start_addr", 32'(m.IMemAddr), 0);
    chk("start_valid", 32'(IFID_Valid), 0);
    for (int i = 1; i <= 4; i++) begin
      step;
      chk("seq_pcn", 32'(PCNext), 32'(i));
      chk("seq_instr", Instruction, w(i - 1));
      chk("seq_valid", 32'(IFID_Valid), 1);
    end
    step;
    zw = 0;
    ack_f = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step;
      chk("wait_addr", 32'(m.IMemAddr), 5);
      chk("wait_req", 32'(m.IMemReq), 1);
      chk("wait_pcn", 32'(PCNext), 5);
    end
    ack_f = 1;
    step;
    chk("late_pcn", 32'(PCNext), 6);
    chk("late_instr", Instruction, w(5));
    zw = 1;
    ack_f = 0;
    step(2);
    chk("pre_stall_pcn", 32'(PCNext), 8);
    chk("pre_stall_addr", 32'(m.IMemAddr), 8);
    Stall = 1;
    step;
    chk("hold_req", 32'(m.IMemReq), 0);
    chk("hold_pcn", 32'(PCNext), 8);
    chk("hold_instr", Instruction, w(7));
    step;
    chk("hold2_req", 32'(m.IMemReq), 0);
    chk("hold2_pcn", 32'(PCNext), 8);
    Stall = 0;
    step;
    chk("unhold_pcn", 32'(PCNext), 9);
    chk("unhold_instr", Instruction, w(8));
    chk("unhold_req", 32'(m.IMemReq), 1);
    chk("unhold_addr", 32'(m.IMemAddr), 9);
    step;
    chk("pc10_pcn", 32'(PCNext), 10);
    zw = 0;
    step;
    chk("pc10_addr", 32'(m.IMemAddr), 10);
    Branch = 1;
    Iguales = 1;
    ALUR = 20;
    step;
    chk("drain_req", 32'(m.IMemReq), 1);
    chk("drain_addr", 32'(m.IMemAddr), 10);
    chk("drain_valid", 32'(IFID_Valid), 0);
    chk("drain_instr", Instruction, 0);
    Branch = 0;
    Iguales = 0;
    ack_f = 1;
    step;
    chk("tgt_addr", 32'(m.IMemAddr), 20);
    chk("tgt_valid", 32'(IFID_Valid), 0);
    chk("tgt_instr", Instruction, 0);
    zw = 1;
    ack_f = 0;
    step;
    chk("tgt_fetch_valid", 32'(IFID_Valid), 1);
    chk("tgt_fetch_instr", Instruction, w(20));
    chk("tgt_fetch_pcn", 32'(PCNext), 21);
    Branch = 1;
    Iguales = 1;
    ALUR = 12;
    step;
    chk("br0_addr", 32'(m.IMemAddr), 12);
    chk("br0_valid", 32'(IFID_Valid), 0);
    Branch = 0;
    Iguales = 0;
    step;
    chk("br0_pcn", 32'(PCNext), 13);
    Stall = 1;
    step;
    chk("exc_pre_req", 32'(m.IMemReq), 0);
    chk("exc_pre_pcn", 32'(PCNext), 13);
    Exception = 1;
    step;
    chk("exc_epc", 32'(EPC), 12);
    chk("exc_valid", 32'(IFID_Valid), 0);
    chk("exc_instr", Instruction, 0);
    chk("exc_req", 32'(m.IMemReq), 1);
    chk("exc_addr", 32'(m.IMemAddr), 60);
    Exception = 0;
    Stall = 0;
    step;
    chk("vec_pcn", 32'(PCNext), 61);
    chk("vec_instr", Instruction, w(60));
    step(2);
    chk("pc63_pcn", 32'(PCNext), 63);
    step;
    chk("wrap_pcn", 32'(PCNext), 0);
    chk("wrap_addr", 32'(m.IMemAddr), 0);
    chk("wrap_instr", Instruction, w(63));
    zw = 0;
    ack_f = 0;
    Branch = 1;
    Iguales = 1;
    ALUR = 30;
    step;
    chk("rdrain_req", 32'(m.IMemReq), 1);
    chk("rdrain_addr", 32'(m.IMemAddr), 0);
    Branch = 0;
    Iguales = 0;
    rst = 0;
    step;
    chk("rst2_req", 32'(m.IMemReq), 0);
    chk("rst2_valid", 32'(IFID_Valid), 0);
    chk("rst2_epc", 32'(EPC), 0);
    ack_f = 1;
    rst = 1;
    step;
    chk("rst2_start_req", 32'(m.IMemReq), 1);
    chk("rst2_start_addr", 32'(m.IMemAddr), 0);
    chk("rst2_start_valid", 32'(IFID_Valid), 0);
    step;
    chk("rst2_pcn", 32'(PCNext), 1);
    chk("rst2_instr", Instruction, w(0));
    IF_Flush = 1;
    step;
    chk("flush_valid", 32'(IFID_Valid), 0);
    chk("flush_instr", Instruction, 0);
    chk("flush_addr", 32'(m.IMemAddr), 2);
    IF_Flush = 0;
    step;
    chk("post_flush_pcn", 32'(PCNext), 3);
    chk("post_flush_instr", Instruction, w(2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
